riscv_rr_mux: RTL and testbench
===============================

RISCV_RR_MUX -- requirements
Module: riscv_rr_mux

Interface
REQ-001 SHALL have parameter N_MUX_IN, default 3, number of input channels (2..16).
REQ-002 SHALL have parameter DW, default 32, data width per channel.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_mux_concat_data  input  N_MUX_IN*DW  channel k data at bits [k*DW +: DW].
REQ-006 SHALL have port i_mux_valid  input  N_MUX_IN  per-channel valid.
REQ-007 SHALL have port i_mux_last  input  N_MUX_IN  per-channel last-beat flag; used only with lock feature.
REQ-008 SHALL have port o_mux_ready  output  N_MUX_IN  per-channel ready, combinational, one-hot or zero.
REQ-009 SHALL have port o_mux_data  output  DW  registered selected data.
REQ-010 SHALL have port o_mux_sel  output  $clog2(N_MUX_IN)  registered index of channel that supplied o_mux_data.
REQ-011 SHALL have port o_mux_valid  output  1  output register holds a beat.
REQ-012 SHALL have port i_mux_ready  input  1  downstream accepts beat when high with o_mux_valid.

Function
REQ-013 SHALL define load = !o_mux_valid || i_mux_ready; input acceptance only when load is high.
REQ-014 SHALL grant, when load and any i_mux_valid, the first valid channel at or after rr_ptr, searching upward modulo N_MUX_IN.
REQ-015 SHALL assert o_mux_ready[grant] only; channel transfer = i_mux_valid[k] && o_mux_ready[k].
REQ-016 SHALL on transfer capture data and index into o_mux_data/o_mux_sel, set o_mux_valid, set rr_ptr = (grant+1) mod N_MUX_IN (wraps N_MUX_IN-1 -> 0).
REQ-017 SHALL clear o_mux_valid when i_mux_ready high, o_mux_valid high, and no transfer that cycle; hold o_mux_data/o_mux_sel unchanged.
REQ-018 SHALL hold output register and rr_ptr stable while o_mux_valid && !i_mux_ready; o_mux_ready all zero.
REQ-019 SHALL give latency of exactly 1 cycle input transfer -> o_mux_valid, and sustain one beat per cycle under continuous i_mux_ready.
REQ-020 SHALL not change o_mux_ready combinationally from i_mux_valid of non-granted channels beyond the priority search (no loop through i_mux_ready to o_mux_valid).
REQ-021 SHALL leave rr_ptr unchanged when no channel valid.

Reset
REQ-022 SHALL on i_rst high at a clock edge set o_mux_valid=0, o_mux_data=0, o_mux_sel=0, rr_ptr=0, lock state cleared, regardless of in-flight beat (beat discarded).
REQ-023 SHALL drive o_mux_ready all zero while i_rst is high.

Configuration
REQ-024 SHALL with macro RISCV_RR_MUX_LOCK_EN defined: transfer with i_mux_last[k]=0 locks grant to channel k; only k granted until its transfer with i_mux_last[k]=1, which unlocks; rr_ptr advances only on unlock.
REQ-025 SHALL while locked and channel k not valid, grant no channel even if others valid.
REQ-026 SHALL without RISCV_RR_MUX_LOCK_EN: ignore i_mux_last, arbitrate every beat per REQ-014, no lock register synthesised.

Structure
REQ-027 SHALL place width helper constants and grant-index function in shared package riscv_mux_pkg.
REQ-028 SHALL implement priority search in sub-module riscv_rr_arbiter (inputs req, ptr; outputs grant one-hot, grant index, any).

Verification (N_MUX_IN=3, DW=32)
REQ-029 SHALL test reset: i_rst=1 for 2 cycles with all valid -> o_mux_valid=0, o_mux_data=0, o_mux_ready=3'b000.
REQ-030 SHALL test fairness: all valid, data A/B/C=32'h11/22/33, i_mux_ready=1 -> o_mux_sel sequence 0,1,2,0 with matching data, one beat per cycle.
REQ-031 SHALL test backpressure: i_mux_ready=0 for 4 cycles after beat 32'h22 -> o_mux_data holds 32'h22, o_mux_ready=000, then resumes with next channel.
REQ-032 SHALL test skip/wrap: rr_ptr=2, only ch0 valid (32'hA5) -> grant ch0, o_mux_sel=0, rr_ptr becomes 1.
REQ-033 SHALL test lock (macro defined): ch1 beats last=0,0,1 with ch0/ch2 valid -> three consecutive o_mux_sel=1, then o_mux_sel=2.
REQ-034 SHALL test reset mid-stream: i_rst asserted while o_mux_valid=1 -> next cycle o_mux_valid=0, first post-reset grant ch0.

Source files
------------

// File: rtl/riscv_mux_pkg.sv
// Shared width helpers and one-hot to index conversion for the round-robin output mux.
package riscv_mux_pkg;

  localparam int unsigned MaxMuxIn = 16;
  localparam int unsigned MaxIdxW  = 4;

  // Index width for an n-way selector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MaxIdxW-1:0] onehot_to_idx(input logic [MaxMuxIn-1:0] oh);
    logic [MaxIdxW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxMuxIn; i++) begin
      if (oh[i]) idx = idx | MaxIdxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Combinational round-robin priority search: first requester at or after ptr_i, modulo N.
module riscv_rr_arbiter
  import riscv_mux_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic                found;
  int unsigned         cand;
  logic [MaxMuxIn-1:0] gnt_ext;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign gnt_ext = MaxMuxIn'(gnt_o);
  assign idx_o   = IW'(onehot_to_idx(gnt_ext));
  assign any_o   = found;

endmodule

// File: rtl/riscv_rr_mux.sv
// Round-robin N-way mux with a registered output stage.
// Define RISCV_RR_MUX_LOCK_EN to hold the grant on one channel until its last beat.
module riscv_rr_mux
  import riscv_mux_pkg::*;
#(
  parameter int unsigned N_MUX_IN = 3,
  parameter int unsigned DW       = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_MUX_IN*DW-1:0]      i_mux_concat_data,
  input  logic [N_MUX_IN-1:0]         i_mux_valid,
  input  logic [N_MUX_IN-1:0]         i_mux_last,
  output logic [N_MUX_IN-1:0]         o_mux_ready,
  output logic [DW-1:0]               o_mux_data,
  output logic [$clog2(N_MUX_IN)-1:0] o_mux_sel,
  output logic                        o_mux_valid,
  input  logic                        i_mux_ready
);

  localparam int unsigned IW = idx_width(N_MUX_IN);

  logic [DW-1:0]       data_q, data_d;
  logic [IW-1:0]       sel_q, sel_d;
  logic                valid_q, valid_d;
  logic [IW-1:0]       ptr_q, ptr_d;

  logic                load;
  logic [N_MUX_IN-1:0] req;
  logic [N_MUX_IN-1:0] gnt;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;
  logic                xfer;
  logic [IW-1:0]       ptr_next;

`ifdef RISCV_RR_MUX_LOCK_EN
  logic                lock_q, lock_d;
  logic [IW-1:0]       lock_ch_q, lock_ch_d;
  logic [N_MUX_IN-1:0] lock_mask;

  // While locked only the owning channel may request; others are masked out.
  always_comb begin
    lock_mask = '0;
    lock_mask[lock_ch_q] = 1'b1;
    req = lock_q ? (i_mux_valid & lock_mask) : i_mux_valid;
  end
`else
  logic unused_last;
  assign unused_last = ^i_mux_last;
  assign req = i_mux_valid;
`endif

  assign load = !valid_q || i_mux_ready;

  riscv_rr_arbiter #(
    .N  (N_MUX_IN),
    .IW (IW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign o_mux_ready = (load && !i_rst) ? gnt : '0;
  assign xfer        = load && gnt_any && !i_rst;
  assign ptr_next    = (gnt_idx == IW'(N_MUX_IN - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef RISCV_RR_MUX_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
`endif
    if (xfer) begin
      data_d  = i_mux_concat_data[gnt_idx*DW +: DW];
      sel_d   = gnt_idx;
      valid_d = 1'b1;
`ifdef RISCV_RR_MUX_LOCK_EN
      lock_d    = !i_mux_last[gnt_idx];
      lock_ch_d = gnt_idx;
      if (i_mux_last[gnt_idx]) ptr_d = ptr_next;
`else
      ptr_d = ptr_next;
`endif
    end else if (i_mux_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
`ifdef RISCV_RR_MUX_LOCK_EN
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
`endif
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef RISCV_RR_MUX_LOCK_EN
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
`endif
    end
  end

  assign o_mux_data  = data_q;
  assign o_mux_sel   = sel_q;
  assign o_mux_valid = valid_q;

endmodule

// File: tb/tb_riscv_rr_mux.sv
// Directed bench for riscv_rr_mux with N_MUX_IN=3, DW=32.
module tb_riscv_rr_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] cdata;
  logic [2:0]  vld;
  logic [2:0]  last;
  logic [2:0]  rdy;
  logic [31:0] odata;
  logic [1:0]  osel;
  logic        ovld;
  logic        drdy;

  int errors = 0;
  int checks = 0;

  riscv_rr_mux #(
    .N_MUX_IN (3),
    .DW       (32)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_mux_concat_data (cdata),
    .i_mux_valid       (vld),
    .i_mux_last        (last),
    .o_mux_ready       (rdy),
    .o_mux_data        (odata),
    .o_mux_sel         (osel),
    .o_mux_valid       (ovld),
    .i_mux_ready       (drdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] sel, input logic [31:0] data);
    chk({tag, "_valid"}, 32'(ovld), 32'd1);
    chk({tag, "_sel"}, 32'(osel), 32'(sel));
    chk({tag, "_data"}, odata, data);
  endtask

  initial begin
    rst   = 1'b1;
    cdata = {32'h33, 32'h22, 32'h11};
    vld   = 3'b111;
    last  = 3'b000;
    drdy  = 1'b1;

    // Reset with all channels valid.
    #1;
    chk("rst_ready_comb", 32'(rdy), 32'd0);
    step();
    step();
    chk("rst_valid", 32'(ovld), 32'd0);
    chk("rst_data", odata, 32'd0);
    chk("rst_sel", 32'(osel), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);

    // Fairness: 0,1,2,0 one beat per cycle.
    rst = 1'b0;
    #1;
    chk("fair_ready0", 32'(rdy), 32'b001);
    step();
    chk_beat("fair0", 2'd0, 32'h11);
    chk("fair_ready1", 32'(rdy), 32'b010);
    step();
    chk_beat("fair1", 2'd1, 32'h22);
    chk("fair_ready2", 32'(rdy), 32'b100);
    step();
    chk_beat("fair2", 2'd2, 32'h33);
    step();
    chk_beat("fair3", 2'd0, 32'h11);
    step();
    chk_beat("bp_beat", 2'd1, 32'h22);

    // Backpressure for 4 cycles after beat 0x22.
    drdy = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready", 32'(rdy), 32'b000);
      step();
      chk_beat("bp_hold", 2'd1, 32'h22);
    end
    drdy = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(rdy), 32'b100);
    step();
    chk_beat("bp_resume", 2'd2, 32'h33);

    // Skip/wrap: move rr_ptr to 2 via ch1, then only ch0 valid.
    vld = 3'b010;
    step();
    chk_beat("ptr_to2", 2'd1, 32'h22);
    vld   = 3'b001;
    cdata = {32'h33, 32'h22, 32'hA5};
    #1;
    chk("wrap_ready", 32'(rdy), 32'b001);
    step();
    chk_beat("wrap", 2'd0, 32'hA5);
    vld = 3'b111;
    #1;
    chk("wrap_ptr1", 32'(rdy), 32'b010);

    // Drain with no valid: output clears, data held, rr_ptr unchanged.
    vld = 3'b000;
    step();
    chk("drain_valid", 32'(ovld), 32'd0);
    chk("drain_data", odata, 32'hA5);
    step();
    vld = 3'b111;
    #1;
    chk("idle_ptr_kept", 32'(rdy), 32'b010);
    cdata = {32'h33, 32'h22, 32'h11};

`ifdef RISCV_RR_MUX_LOCK_EN
    // Lock: ch1 beats last=0,0,1 hold the grant despite ch0/ch2 valid.
    last = 3'b000;
    step();
    chk_beat("lock0", 2'd1, 32'h22);
    vld = 3'b101;
    #1;
    chk("lock_starve", 32'(rdy), 32'b000);
    vld = 3'b111;
    #1;
    chk("lock_ready", 32'(rdy), 32'b010);
    step();
    chk_beat("lock1", 2'd1, 32'h22);
    last = 3'b010;
    step();
    chk_beat("lock2", 2'd1, 32'h22);
    last = 3'b000;
    step();
    chk_beat("unlock", 2'd2, 32'h33);
`else
    step();
    chk_beat("nolock", 2'd1, 32'h22);
`endif

    // Reset mid-stream while a beat is held.
    chk("pre_rst_valid", 32'(ovld), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(rdy), 32'b000);
    step();
    chk("midrst_valid", 32'(ovld), 32'd0);
    chk("midrst_data", odata, 32'd0);
    chk("midrst_sel", 32'(osel), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(rdy), 32'b001);
    step();
    chk_beat("post_rst", 2'd0, 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
